// File: rtl/gpu_regfile_arbiter.sv
// gpu_regfile_arbiter
// Shares the single-read/single-write GPU register file between the command
// decoder (requester 0) and the host bus bridge (requester 1).
// Acceptance is combinational (ackN). Register-file controls are registered
// and valid in the cycle after acceptance. Read data returns two cycles after
// acceptance on the shared rdata bus, qualified by rvalidN.
// Optional feature macro: GPU_RR_ARB_EN
//   - defined:   round-robin arbitration with a 1-bit preferred-requester pointer
//   - undefined: fixed priority, requester 0 always wins a conflict
module gpu_regfile_arbiter #(
  parameter int D_WIDTH  = 16,
  parameter int A_WIDTH  = 4,
  parameter int RF_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0,
  input  logic               we0,
  input  logic [A_WIDTH-1:0] addr0,
  input  logic [D_WIDTH-1:0] wdata0,
  input  logic               req1,
  input  logic               we1,
  input  logic [A_WIDTH-1:0] addr1,
  input  logic [D_WIDTH-1:0] wdata1,
  output logic               ack0,
  output logic               ack1,
  output logic [D_WIDTH-1:0] rdata,
  output logic               rvalid0,
  output logic               rvalid1,
  output logic               err0,
  output logic               err1,
  output logic               rf_we,
  output logic [A_WIDTH-1:0] rf_waddr,
  output logic [A_WIDTH-1:0] rf_raddr,
  output logic [D_WIDTH-1:0] rf_wdata,
  input  logic [D_WIDTH-1:0] rf_rdata
);

  // Depth widened by one bit so RF_DEPTH == 2**A_WIDTH still compares correctly.
  localparam logic [A_WIDTH:0] DEPTH_C = (A_WIDTH+1)'(RF_DEPTH);

  logic               grant0_s;
  logic               grant1_s;
  logic               accept_s;
  logic               sel_id_s;
  logic               sel_we_s;
  logic [A_WIDTH-1:0] sel_addr_s;
  logic [D_WIDTH-1:0] sel_wdata_s;
  logic               in_range_s;

  logic               rf_we_r;
  logic [A_WIDTH-1:0] rf_waddr_r;
  logic [A_WIDTH-1:0] rf_raddr_r;
  logic [D_WIDTH-1:0] rf_wdata_r;
  logic               err0_r;
  logic               err1_r;
  logic               rd_pend_r;
  logic               rd_id_r;
  logic [D_WIDTH-1:0] rdata_r;
  logic               rvalid0_r;
  logic               rvalid1_r;

`ifdef GPU_RR_ARB_EN
  // Preferred requester on conflict: 0 = requester 0, 1 = requester 1.
  logic               ptr_r;
`endif

  // Arbitration: at most one grant, only to an active requester, none in reset.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (!rst_n) begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end else if (req0 && req1) begin
`ifdef GPU_RR_ARB_EN
      if (ptr_r == 1'b0) begin
        grant0_s = 1'b1;
      end else begin
        grant1_s = 1'b1;
      end
`else
      grant0_s = 1'b1;
`endif
    end else if (req0) begin
      grant0_s = 1'b1;
    end else if (req1) begin
      grant1_s = 1'b1;
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Select the winning request's fields and classify its address.
  always_comb begin
    accept_s    = grant0_s | grant1_s;
    sel_id_s    = grant1_s;
    sel_we_s    = 1'b0;
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    if (grant1_s) begin
      sel_we_s    = we1;
      sel_addr_s  = addr1;
      sel_wdata_s = wdata1;
    end else begin
      sel_we_s    = we0;
      sel_addr_s  = addr0;
      sel_wdata_s = wdata0;
    end
    in_range_s = ({1'b0, sel_addr_s} < DEPTH_C);
  end

  // Stage 1: register-file controls, error pulses and read-in-flight tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_r    <= 1'b0;
      rf_waddr_r <= '0;
      rf_raddr_r <= '0;
      rf_wdata_r <= '0;
      err0_r     <= 1'b0;
      err1_r     <= 1'b0;
      rd_pend_r  <= 1'b0;
      rd_id_r    <= 1'b0;
    end else begin
      rf_we_r   <= accept_s & sel_we_s & in_range_s;
      err0_r    <= accept_s & ~sel_id_s & ~in_range_s;
      err1_r    <= accept_s & sel_id_s & ~in_range_s;
      rd_pend_r <= accept_s & ~sel_we_s & in_range_s;
      if (accept_s && sel_we_s && in_range_s) begin
        rf_waddr_r <= sel_addr_s;
        rf_wdata_r <= sel_wdata_s;
      end
      if (accept_s && !sel_we_s && in_range_s) begin
        rf_raddr_r <= sel_addr_s;
        rd_id_r    <= sel_id_s;
      end
    end
  end

  // Stage 2: capture register-file read data and steer rvalid to the owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r   <= '0;
      rvalid0_r <= 1'b0;
      rvalid1_r <= 1'b0;
    end else begin
      rvalid0_r <= rd_pend_r & ~rd_id_r;
      rvalid1_r <= rd_pend_r & rd_id_r;
      if (rd_pend_r) begin
        rdata_r <= rf_rdata;
      end
    end
  end

`ifdef GPU_RR_ARB_EN
  // Round-robin pointer: after each transfer prefer the requester not just served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= 1'b0;
    end else if (accept_s) begin
      ptr_r <= ~sel_id_s;
    end
  end
`endif

  assign ack0     = grant0_s;
  assign ack1     = grant1_s;
  assign rf_we    = rf_we_r;
  assign rf_waddr = rf_waddr_r;
  assign rf_raddr = rf_raddr_r;
  assign rf_wdata = rf_wdata_r;
  assign err0     = err0_r;
  assign err1     = err1_r;
  assign rdata    = rdata_r;
  assign rvalid0  = rvalid0_r;
  assign rvalid1  = rvalid1_r;

endmodule
